// File: rtl/amber_wb_pkg.sv
// Shared types and bus widths for the Amber Wishbone arbiter.
// Imported by amber_wb_arbiter and amber_wb_arb_watchdog.
package amber_wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1
  } arb_state_t;

endpackage

// File: rtl/amber_wb_arb_watchdog.sv
// Stall counter for the arbiter: one-cycle timeout pulse after TIMEOUT
// stalled strobe cycles. Only built under AMBER_WB_ARB_TIMEOUT_EN.
module amber_wb_arb_watchdog
  import amber_wb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_err,
  input  logic i_chg,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_timeout = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_chg || o_timeout || !i_stb || i_ack || i_err)
      cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/amber_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with cyc bus locking.
// Define AMBER_WB_ARB_TIMEOUT_EN to add the stall watchdog.
module amber_wb_arbiter
  import amber_wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ADR_W-1:0]   i_m0_adr,
  input  logic [DAT_W/8-1:0] i_m0_sel,
  input  logic               i_m0_we,
  input  logic [DAT_W-1:0]   i_m0_dat,
  input  logic               i_m0_cyc,
  input  logic               i_m0_stb,
  input  logic [ADR_W-1:0]   i_m1_adr,
  input  logic [DAT_W/8-1:0] i_m1_sel,
  input  logic               i_m1_we,
  input  logic [DAT_W-1:0]   i_m1_dat,
  input  logic               i_m1_cyc,
  input  logic               i_m1_stb,
  output logic [DAT_W-1:0]   o_m0_dat,
  output logic               o_m0_ack,
  output logic               o_m0_err,
  output logic [DAT_W-1:0]   o_m1_dat,
  output logic               o_m1_ack,
  output logic               o_m1_err,
  output logic [ADR_W-1:0]   o_s_adr,
  output logic [DAT_W/8-1:0] o_s_sel,
  output logic               o_s_we,
  output logic [DAT_W-1:0]   o_s_dat,
  output logic               o_s_cyc,
  output logic               o_s_stb,
  input  logic [DAT_W-1:0]   i_s_dat,
  input  logic               i_s_ack,
  input  logic               i_s_err,
  output logic [1:0]         o_grant
);

  arb_state_t state_q;
  logic       last_q;
  logic       own0, own1;
  logic       own_stb;
  logic       tmo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (i_m0_cyc && i_m1_cyc)
            state_q <= last_q ? ARB_OWN0 : ARB_OWN1;
          else if (i_m0_cyc)
            state_q <= ARB_OWN0;
          else if (i_m1_cyc)
            state_q <= ARB_OWN1;
        end
        ARB_OWN0: begin
          if (!i_m0_cyc) begin
            last_q  <= 1'b0;
            state_q <= i_m1_cyc ? ARB_OWN1 : ARB_IDLE;
          end
        end
        ARB_OWN1: begin
          if (!i_m1_cyc) begin
            last_q  <= 1'b1;
            state_q <= i_m0_cyc ? ARB_OWN0 : ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign own0    = (state_q == ARB_OWN0);
  assign own1    = (state_q == ARB_OWN1);
  assign o_grant = {own1, own0};
  assign own_stb = (own0 & i_m0_stb) | (own1 & i_m1_stb);

`ifdef AMBER_WB_ARB_TIMEOUT_EN
  logic chg;

  // Any ownership transition at the next edge restarts the stall count.
  assign chg = own0 ? !i_m0_cyc
             : own1 ? !i_m1_cyc
             : (i_m0_cyc | i_m1_cyc);

  amber_wb_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_stb    (own_stb),
    .i_ack    (i_s_ack),
    .i_err    (i_s_err),
    .i_chg    (chg),
    .o_timeout(tmo)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo = 1'b0;
`endif

  always_comb begin
    o_s_adr = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    o_s_dat = '0;
    o_s_cyc = 1'b0;
    if (own0) begin
      o_s_adr = i_m0_adr;
      o_s_sel = i_m0_sel;
      o_s_we  = i_m0_we;
      o_s_dat = i_m0_dat;
      o_s_cyc = i_m0_cyc;
    end else if (own1) begin
      o_s_adr = i_m1_adr;
      o_s_sel = i_m1_sel;
      o_s_we  = i_m1_we;
      o_s_dat = i_m1_dat;
      o_s_cyc = i_m1_cyc;
    end
  end

  assign o_s_stb  = own_stb & ~tmo;

  assign o_m0_ack = own0 & i_m0_stb & i_s_ack;
  assign o_m1_ack = own1 & i_m1_stb & i_s_ack;
  assign o_m0_err = own0 & ((i_m0_stb & i_s_err) | tmo);
  assign o_m1_err = own1 & ((i_m1_stb & i_s_err) | tmo);
  assign o_m0_dat = own0 ? i_s_dat : '0;
  assign o_m1_dat = own1 ? i_s_dat : '0;

endmodule

// File: tb/tb_amber_wb_arbiter.sv
// Bench for amber_wb_arbiter: directed scenarios plus random traffic
// checked against a cycle-level ownership model.
module tb_amber_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] m_adr;
  logic [1:0][SW-1:0] m_sel;
  logic [1:0]         m_we;
  logic [1:0][DW-1:0] m_wdat;
  logic [1:0]         m_cyc;
  logic [1:0]         m_stb;
  logic [DW-1:0]      s_rdat;
  logic               s_ack, s_err;

  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic          s_we, s_cyc, s_stb;
  logic [DW-1:0] s_wdat;
  logic [1:0]    grant;

  amber_wb_arbiter #(
    .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_adr(m_adr[0]), .i_m0_sel(m_sel[0]), .i_m0_we(m_we[0]),
    .i_m0_dat(m_wdat[0]), .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]),
    .i_m1_adr(m_adr[1]), .i_m1_sel(m_sel[1]), .i_m1_we(m_we[1]),
    .i_m1_dat(m_wdat[1]), .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_adr(s_adr), .o_s_sel(s_sel), .o_s_we(s_we),
    .o_s_dat(s_wdat), .o_s_cyc(s_cyc), .o_s_stb(s_stb),
    .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(grant)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: owner -1 = idle, else master index.
  int owner = -1;
  int last  = 1;
  int stall = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic timeout_now();
`ifdef AMBER_WB_ARB_TIMEOUT_EN
    return owner >= 0 && stall == TO;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    logic ostb, to;
    logic [1:0] g;
    ostb = (owner >= 0) ? m_stb[owner] : 1'b0;
    to   = timeout_now();
    g    = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    chk("grant", grant, g);
    chk("s_cyc", s_cyc, (owner >= 0) ? m_cyc[owner] : 1'b0);
    chk("s_stb", s_stb, ostb & ~to);
    chk("s_adr", s_adr, (owner >= 0) ? m_adr[owner] : '0);
    chk("s_sel", s_sel, (owner >= 0) ? m_sel[owner] : '0);
    chk("s_we", s_we, (owner >= 0) ? m_we[owner] : 1'b0);
    chk("s_wdat", s_wdat, (owner >= 0) ? m_wdat[owner] : '0);
    for (int i = 0; i < 2; i++) begin
      logic own;
      own = (owner == i);
      chk("m_ack", i == 0 ? m0_ack : m1_ack, own & m_stb[i] & s_ack);
      chk("m_err", i == 0 ? m0_err : m1_err,
          own & ((m_stb[i] & s_err) | to));
      chk("m_dat", i == 0 ? m0_rdat : m1_rdat, own ? s_rdat : '0);
    end
  endtask

  task automatic step_model();
    int nxt;
    logic ostb, to;
    ostb = (owner >= 0) ? m_stb[owner] : 1'b0;
    to   = timeout_now();
    if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) nxt = 1 - last;
      else if (m_cyc[0])        nxt = 0;
      else if (m_cyc[1])        nxt = 1;
      else                      nxt = -1;
    end else if (m_cyc[owner]) begin
      nxt = owner;
    end else begin
      last = owner;
      nxt  = m_cyc[1 - owner] ? 1 - owner : -1;
    end
    if (nxt != owner || to || !ostb || s_ack || s_err) stall = 0;
    else stall = stall + 1;
    owner = nxt;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic run_cycle();
    #1 check_all();
    @(posedge clk);
    if (rst_n) step_model();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_adr = '0; m_sel = '0; m_we = '0; m_wdat = '0;
    m_cyc = '0; m_stb = '0;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  // Reset asserted between edges, checked immediately, released at negedge.
  task automatic async_reset();
    @(posedge clk);
    step_model();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_stb", s_stb, 1'b0);
    chk("rst_s_adr", s_adr, '0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_m0_dat", m0_rdat, '0);
    owner = -1; last = 1; stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < 2; i++) begin
      if ($urandom_range(3) == 0) m_cyc[i] = ~m_cyc[i];
      m_stb[i]  = m_cyc[i] & 1'($urandom_range(1));
      m_adr[i]  = $urandom;
      m_sel[i]  = 16'($urandom);
      m_we[i]   = 1'($urandom_range(1));
      m_wdat[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    s_ack  = ($urandom_range(3) == 0);
    s_err  = ($urandom_range(15) == 0);
    s_rdat = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [DW-1:0] beef;
    clear_inputs();
    #2;
    chk("por_grant", grant, 2'b00);
    chk("por_s_cyc", s_cyc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single master with a two-cycle slave.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100;
    run_cycle();
    chk("t1_grant", grant, 2'b01);
    run_cycle();
    beef = 128'hDEADBEEF;
    s_ack = 1'b1; s_rdat = beef;
    #1;
    chk("t1_ack", m0_ack, 1'b1);
    chk("t1_dat", m0_rdat, beef);
    chk("t1_m1_ack", m1_ack, 1'b0);
    run_cycle();
    clear_inputs();
    run_cycle();

    // Tie after reset goes to m0, then direct handover.
    async_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    run_cycle();
    chk("tie_grant", grant, 2'b01);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    run_cycle();
    chk("handover", grant, 2'b10);
    clear_inputs();
    run_cycle();

    // Round-robin under continuous requests.
    async_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    run_cycle();
    for (int k = 0; k < 4; k++) begin
      int cur;
      cur = k % 2;
      chk("rr_grant", grant, (cur == 0) ? 2'b01 : 2'b10);
      s_ack = 1'b1;
      run_cycle();
      s_ack = 1'b0; m_cyc[cur] = 1'b0; m_stb[cur] = 1'b0;
      run_cycle();
      m_cyc[cur] = 1'b1; m_stb[cur] = 1'b1;
    end
    clear_inputs();
    run_cycle();

    // Lock: m1 holds cyc, m0 starves.
    async_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    run_cycle();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("lock_grant", grant, 2'b10);
      chk("lock_m0_ack", m0_ack, 1'b0);
      run_cycle();
    end

    // Reset mid-transfer, then tie again goes to m0.
    async_reset();
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b0;
    run_cycle();
    chk("post_rst_grant", grant, 2'b01);
    clear_inputs();
    run_cycle();
    run_cycle();

    // Watchdog on a never-acking slave.
    async_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    run_cycle();
    for (int k = 0; k < TO; k++) begin
      #1 chk("to_pre_err", m0_err, 1'b0);
      run_cycle();
    end
    #1;
`ifdef AMBER_WB_ARB_TIMEOUT_EN
    chk("to_err", m0_err, 1'b1);
    chk("to_stb", s_stb, 1'b0);
`else
    chk("no_to_err", m0_err, 1'b0);
    chk("no_to_stb", s_stb, 1'b1);
`endif
    run_cycle();
    #1 chk("to_err_once", m0_err, 1'b0);
    run_cycle();
    clear_inputs();
    run_cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) async_reset();
      rand_drive();
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
